angle_wrap: RTL and testbench

ANGLE_WRAP -- requirements
Module: angle_wrap

---
 rtl/angle_wrap.sv | 115 +++++++++++
 tb/tb_angle_wrap.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/angle_wrap.sv
// Wraps a signed 16.16 degree angle into [-90, +90) by exact restoring mod-180 reduction.
// Build option: define ANGLE_WRAP_POLE_EN to compute near_pole; otherwise near_pole is tied to 0.
module angle_wrap #(
    parameter logic [31:0] POLE_TOL = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] angle_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] angle_out,
    output logic        near_pole
);

    localparam logic [32:0] DEG180_W = 33'h0_00B4_0000;
    localparam logic [31:0] DEG180   = 32'h00B4_0000;
    localparam logic [31:0] DEG90    = 32'h005A_0000;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t      state;
    logic [32:0] rem;
    logic        sign;
    logic [2:0]  k;
    logic        idle_q;
    logic        ov_q;
    logic [31:0] ang_q;

    logic [32:0] ext;
    logic [32:0] mag;
    logic [32:0] step_div;
    logic [31:0] folded;
    logic [31:0] result;

    // 33-bit magnitude so that -2^31 stays exact
    always_comb begin
        ext      = {angle_in[31], angle_in};
        mag      = angle_in[31] ? (33'd0 - ext) : ext;
        step_div = DEG180_W << k;
        folded   = (sign && rem != 33'd0) ? (DEG180 - rem[31:0]) : rem[31:0];
        result   = (folded >= DEG90) ? (folded - DEG180) : folded;
    end

    // out_valid rises one cycle after DONE is entered, giving the 10-cycle latency
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state  <= IDLE;
            idle_q <= 1'b1;
            ov_q   <= 1'b0;
            ang_q  <= 32'd0;
            rem    <= 33'd0;
            sign   <= 1'b0;
            k      <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem    <= mag;
                        sign   <= angle_in[31];
                        k      <= 3'd7;
                        idle_q <= 1'b0;
                        state  <= ITER;
                    end
                end
                ITER: begin
                    if (rem >= step_div)
                        rem <= rem - step_div;
                    k <= k - 3'd1;
                    if (k == 3'd0)
                        state <= FIX;
                end
                FIX: begin
                    ang_q <= result;
                    state <= DONE;
                end
                DONE: begin
                    if (!ov_q) begin
                        ov_q <= 1'b1;
                    end else if (out_ready) begin
                        ov_q   <= 1'b0;
                        idle_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated with reset so in_ready is low while reset is held and high right after release
    assign in_ready  = idle_q & ~rst_n;
    assign out_valid = ov_q;
    assign angle_out = ang_q;

`ifdef ANGLE_WRAP_POLE_EN
    localparam logic signed [31:0] POLE_LIM = -32'sh005A_0000 + $signed(POLE_TOL);
    logic pole_q;

    always_ff @(posedge clk) begin
        if (rst_n)
            pole_q <= 1'b0;
        else if (state == FIX)
            pole_q <= ($signed(result) <= POLE_LIM);
    end

    assign near_pole = pole_q;
`else
    logic unused_pole_tol;
    assign unused_pole_tol = ^POLE_TOL;
    assign near_pole = 1'b0;
`endif

endmodule

// File: tb/tb_angle_wrap.sv
// Scoreboard bench for angle_wrap: random and directed angles against a plain modulo model.
module tb_angle_wrap;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] angle_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] angle_out;
    logic        near_pole;

    always #5 clk = ~clk;

    angle_wrap dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .angle_in(angle_in), .out_valid(out_valid), .out_ready(out_ready),
        .angle_out(angle_out), .near_pole(near_pole)
    );

    typedef struct {
        logic [31:0] ang;
        logic        pole;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;
    logic hs_prev = 1'b0;
    logic rnd_ready = 1'b0;

    localparam int FULL = 180 * 65536;
    localparam int POLE_TOL = 256;

    function automatic logic [31:0] ref_wrap(input logic [31:0] a);
        longint m = longint'(FULL);
        longint r;
        r = longint'($signed(a)) % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r[31:0];
    endfunction

    function automatic logic ref_pole(input logic [31:0] w);
        logic en;
`ifdef ANGLE_WRAP_POLE_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && ($signed(w) <= (-(FULL / 2) + POLE_TOL));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pushes on accepted input, checks every cycle a result is presented
    always @(negedge clk) begin
        if (rst_n) begin
            q.delete();
            prev_ov = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
                chk("ov_cleared_after_hs", {31'd0, out_valid}, 32'd0);
            end
            if (in_valid && in_ready)
                q.push_back('{ref_wrap(angle_in), ref_pole(ref_wrap(angle_in)), cyc + 1});
            if (out_valid) begin
                chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: got angle %h expected no output", angle_out);
                end else begin
                    if (!prev_ov) chk("latency", cyc - q[0].acc, 32'd10);
                    chk("angle_out", angle_out, q[0].ang);
                    chk("near_pole", {31'd0, near_pole}, {31'd0, q[0].pole});
                    if (out_ready) void'(q.pop_front());
                end
            end
            hs_prev = out_valid && out_ready;
            prev_ov = out_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] a);
        int t = 0;
        in_valid = 1'b1;
        angle_in = a;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 for %h", a);
            in_valid = 1'b0;
        end else begin
            step();
            in_valid = 1'b0;
            angle_in = $urandom();
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((q.size() != 0 || !in_ready) && t < 300) begin
            step();
            t++;
        end
        if (q.size() != 0 || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dir[$];
        int t;
        int kk;
        dir = '{32'h001E_0000, 32'h00D2_0000, 32'hFF9C_0000, 32'hFF4C_0000,
                32'h005A_0000, 32'h0059_FF00, 32'h8000_0000, 32'h7FFF_0000,
                32'h0000_0000, 32'h005A_0080, 32'h0168_0000, 32'hFFA6_0000,
                32'h0000_0001, 32'hFFFF_FFFF};

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; angle_in = 32'd0;
        step(); step(); step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_angle_out", angle_out, 32'd0);
        chk("rst_near_pole", {31'd0, near_pole}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b1;
        foreach (dir[i]) send(dir[i]);
        wait_idle();

        // Backpressure: hold result for 5 cycles while poking in_valid
        out_ready = 1'b0;
        send(32'h1234_5678);
        t = 0;
        while (!out_valid && t < 30) begin step(); t++; end
        chk("hold_out_valid_seen", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            angle_in = $urandom();
            #1;
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Reset during the 4th ITER cycle discards the result
        send(32'h0100_0000);
        step(); step(); step();
        rst_n = 1'b1;
        step();
        chk("abort_in_ready_in_rst", {31'd0, in_ready}, 32'd0);
        chk("abort_out_valid_in_rst", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready_after", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 14; i++) begin
            step();
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        send(32'h002D_0000);
        wait_idle();

        rnd_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 3)) step();
            kk = int'($urandom_range(0, 362)) - 181;
            case ($urandom_range(0, 3))
                0: send($urandom());
                1: send(32'(kk * FULL));
                2: send(32'(kk * FULL + FULL / 2 + int'($urandom_range(0, 1023)) - 512));
                default: send(32'(kk * FULL - FULL / 2 + int'($urandom_range(0, 1023)) - 512));
            endcase
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
